// File: rtl/l1_result_streamer_pkg.sv
// Shared types and constants for the layer-1 result streamer.
package l1s_pkg;

    localparam int PIX_W       = 13;
    localparam int FRAME_BEATS = 1024;
    localparam int L1_BASE     = 0;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/l1_result_streamer_if.sv
// Valid/ready pixel stream carrying the layer-1 map out of the streamer.
interface l1_result_streamer_if #(
    parameter int DATA_W = l1s_pkg::PIX_W
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/l1_result_streamer_fifo2.sv
// Two-entry FIFO with flush; the caller's credit logic guarantees it never overflows.
module stream_fifo2 #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic [W-1:0] head
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;

    // NOTE: every _d takes its _q as the default first, so no path leaves it unassigned (no latch).
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: non-blocking only in clocked logic; the two data words are reset too so head is never X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/l1_result_streamer.sv
// Streams layer 1 out of the layer memory in raster order after the conv engine
// finishes, and accumulates per-frame max and sum of the accepted beats.
module l1_result_streamer
    import l1s_pkg::*;
#(
    parameter int MAP_W  = 32,
    parameter int DATA_W = PIX_W,
    parameter int ADDR_W = 12,
    parameter int SUM_W  = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 conv_busy,
    output logic                 l1_csel,
    output logic                 l1_rd,
    output logic [ADDR_W-1:0]    l1_addr,
    input  logic [DATA_W-1:0]    l1_rdata,
    l1_result_streamer_if.master m_axis,
    output logic                 done,
    output logic                 err_overrun,
    output logic [DATA_W-1:0]    frame_max,
    output logic [SUM_W-1:0]     frame_sum
);
    localparam int               CNT_W    = $clog2(MAP_W * MAP_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAP_W * MAP_W - 1);

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              inflight_q, inflight_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [SUM_W-1:0]  sum_q, sum_d;

    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_nempty, fifo_push, fifo_pop;
    logic              m_valid, m_last, xfer;
    logic [DATA_W-1:0] m_data;
    logic              trigger, active, abort, credit_ok;

    assign trigger = busy_q & ~conv_busy;
    assign active  = (state_q == STREAM) || (state_q == DRAIN);
    assign abort   = active & conv_busy;

    // Returning read data bypasses an empty FIFO so the first beat is valid the cycle it arrives.
    assign fifo_nempty = (fifo_count != 2'd0);
    assign m_valid     = fifo_nempty | inflight_q;
    assign m_data      = fifo_nempty ? fifo_head : (inflight_q ? l1_rdata : '0);
    assign m_last      = m_valid & (beat_cnt_q == LAST_IDX);
    assign xfer        = m_valid & m_axis.m_ready;
    assign fifo_push   = inflight_q & ~(~fifo_nempty & m_axis.m_ready);
    assign fifo_pop    = fifo_nempty & m_axis.m_ready;
    assign credit_ok   = ({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2;

    stream_fifo2 #(.W(DATA_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (l1_rdata),
        .pop       (fifo_pop),
        .flush     (abort),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    always_comb begin
        state_d    = state_q;
        busy_d     = conv_busy;
        rd_cnt_d   = rd_cnt_q;
        beat_cnt_d = beat_cnt_q;
        max_d      = max_q;
        sum_d      = sum_q;
        err_d      = 1'b0;
        l1_rd      = 1'b0;

        if (xfer) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (m_data > max_q) max_d = m_data;
            sum_d = sum_q + SUM_W'(m_data);
        end

        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d    = STREAM;
                    rd_cnt_d   = '0;
                    beat_cnt_d = '0;
                    max_d      = '0;
                    sum_d      = '0;
                end
            end
            STREAM: begin
                if (credit_ok && !conv_busy) begin
                    l1_rd    = 1'b1;
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    if (rd_cnt_q == LAST_IDX) state_d = DRAIN;
                end
            end
            DRAIN:   if (xfer && m_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // No read is issued while conv_busy is high, so nothing is left in flight after an abort.
        if (abort) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end

    assign inflight_d = l1_rd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            rd_cnt_q   <= '0;
            beat_cnt_q <= '0;
            max_q      <= '0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            rd_cnt_q   <= rd_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            max_q      <= max_d;
            sum_q      <= sum_d;
        end
    end

    assign l1_csel        = active;
    assign l1_addr        = ADDR_W'(L1_BASE) + ADDR_W'(rd_cnt_q);
    assign done           = (state_q == DONE);
    assign err_overrun    = err_q;
    assign frame_max      = max_q;
    assign frame_sum      = sum_q;
    assign m_axis.m_valid = m_valid;
    assign m_axis.m_data  = m_data;
    assign m_axis.m_last  = m_last;

endmodule

// File: tb/tb_l1_result_streamer.sv
// Directed bench for l1_result_streamer: frame vectors from a table plus stall,
// abort and mid-frame reset sequences, checked against a layer-memory model.
module tb_l1_result_streamer;
    import l1s_pkg::*;

    localparam int DATA_W = 13;
    localparam int ADDR_W = 12;
    localparam int SUM_W  = 23;

    logic              clk;
    logic              reset;
    logic              conv_busy;
    logic              l1_csel, l1_rd, done, err_overrun;
    logic [ADDR_W-1:0] l1_addr;
    logic [DATA_W-1:0] l1_rdata;
    logic [DATA_W-1:0] frame_max;
    logic [SUM_W-1:0]  frame_sum;

    l1_result_streamer_if #(.DATA_W(DATA_W)) m_axis ();

    l1_result_streamer #(.MAP_W(32), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SUM_W(SUM_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .conv_busy   (conv_busy),
        .l1_csel     (l1_csel),
        .l1_rd       (l1_rd),
        .l1_addr     (l1_addr),
        .l1_rdata    (l1_rdata),
        .m_axis      (m_axis),
        .done        (done),
        .err_overrun (err_overrun),
        .frame_max   (frame_max),
        .frame_sum   (frame_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pix_t mem [FRAME_BEATS];
    always_ff @(posedge clk) if (l1_rd) l1_rdata <= mem[l1_addr[9:0]];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int ready_rnd = 0;
    int trig_cyc;

    pix_t got_data[$];
    bit   got_last[$];
    int   n_rd, n_done, n_err, outstanding, next_addr;
    int   first_rd_cyc, first_valid_cyc, first_xfer_cyc, last_xfer_cyc, done_cyc;
    int   stall_viol, credit_viol, addr_err;
    bit   prev_stall;
    pix_t prev_data;
    logic prev_last;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    function automatic pix_t exp_pix(input int pattern, input int i);
        case (pattern)
            0:       return pix_t'((i * 8) % 8192);
            1:       return '0;
            default: return 13'h1FF0;
        endcase
    endfunction

    task automatic fill(input int pattern);
        for (int i = 0; i < FRAME_BEATS; i++) mem[i] = exp_pix(pattern, i);
    endtask

    task automatic clear_mon();
        got_data.delete();
        got_last.delete();
        n_rd = 0; n_done = 0; n_err = 0; outstanding = 0; next_addr = 0;
        first_rd_cyc = -1; first_valid_cyc = -1; first_xfer_cyc = -1;
        last_xfer_cyc = -1; done_cyc = -1;
        stall_viol = 0; credit_viol = 0; addr_err = 0; prev_stall = 1'b0;
    endtask

    // Sampling on the falling edge, midway between input changes and active edges.
    initial forever @(posedge clk) cyc++;
    initial forever begin
        @(posedge clk);
        #1;
        if (ready_rnd != 0) m_axis.m_ready = 1'($urandom_range(0, 1));
    end
    initial forever begin
        @(negedge clk);
        if (l1_rd) begin
            if (outstanding >= 2) credit_viol++;
            if (int'(l1_addr) != next_addr) addr_err++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            n_rd++;
            next_addr++;
        end
        if (prev_stall && !(m_axis.m_valid && m_axis.m_data === prev_data && m_axis.m_last === prev_last))
            stall_viol++;
        if (m_axis.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_axis.m_valid && m_axis.m_ready) begin
            got_data.push_back(m_axis.m_data);
            got_last.push_back(m_axis.m_last);
            if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
        end
        outstanding += int'(l1_rd) - int'(m_axis.m_valid && m_axis.m_ready);
        prev_stall = m_axis.m_valid && !m_axis.m_ready && reset;
        prev_data  = m_axis.m_data;
        prev_last  = m_axis.m_last;
        if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (err_overrun) n_err++;
    end

    task automatic check_zero(input string nm);
        check({nm, ".ctl"}, {l1_csel, l1_rd, l1_addr, m_axis.m_valid, m_axis.m_last, done, err_overrun}, '0);
        check({nm, ".m_data"}, m_axis.m_data, '0);
        check({nm, ".frame_max"}, frame_max, '0);
        check({nm, ".frame_sum"}, frame_sum, '0);
    endtask

    task automatic start_frame();
        @(posedge clk);
        #1 conv_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 conv_busy = 1'b0;
        trig_cyc = cyc;
    endtask

    task automatic wait_end(input string nm, input int budget);
        int k;
        k = 0;
        while (n_done == 0 && n_err == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({nm, ".no_timeout"}, k < budget, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_beats(input string nm, input int n, input int budget);
        int k;
        k = 0;
        while (got_data.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({nm, ".beats_reached"}, k < budget, 1);
    endtask

    task automatic verify_frame(input string nm, input int pattern, input int exp_max, input int exp_sum);
        int data_err, last_err;
        data_err = 0;
        last_err = 0;
        foreach (got_data[i]) begin
            if (got_data[i] !== exp_pix(pattern, i)) data_err++;
            if (got_last[i] != (i == FRAME_BEATS - 1)) last_err++;
        end
        check({nm, ".beats"}, got_data.size(), FRAME_BEATS);
        check({nm, ".data_err"}, data_err, 0);
        check({nm, ".last_err"}, last_err, 0);
        check({nm, ".reads"}, n_rd, FRAME_BEATS);
        check({nm, ".addr_err"}, addr_err, 0);
        check({nm, ".stall_viol"}, stall_viol, 0);
        check({nm, ".credit_viol"}, credit_viol, 0);
        check({nm, ".done_pulses"}, n_done, 1);
        check({nm, ".err_pulses"}, n_err, 0);
        check({nm, ".frame_max"}, frame_max, exp_max);
        check({nm, ".frame_sum"}, frame_sum, exp_sum);
        check({nm, ".csel_idle"}, l1_csel, 0);
    endtask

    typedef struct {
        string name;
        int    pattern;
        int    rnd;
        int    exp_max;
        int    exp_sum;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int rd_snap;
        vecs[0] = '{name: "ramp_rdy",  pattern: 0, rnd: 0, exp_max: 8184,    exp_sum: 4190208};
        vecs[1] = '{name: "ramp_rand", pattern: 0, rnd: 1, exp_max: 8184,    exp_sum: 4190208};
        vecs[2] = '{name: "zeros",     pattern: 1, rnd: 0, exp_max: 0,       exp_sum: 0};
        vecs[3] = '{name: "all_1ff0",  pattern: 2, rnd: 0, exp_max: 'h1FF0, exp_sum: 8372224};

        reset = 1'b0;
        conv_busy = 1'b0;
        m_axis.m_ready = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        foreach (vecs[v]) begin
            fill(vecs[v].pattern);
            clear_mon();
            ready_rnd = vecs[v].rnd;
            m_axis.m_ready = 1'b1;
            start_frame();
            wait_end(vecs[v].name, 5000);
            ready_rnd = 0;
            m_axis.m_ready = 1'b1;
            verify_frame(vecs[v].name, vecs[v].pattern, vecs[v].exp_max, vecs[v].exp_sum);
            if (vecs[v].rnd == 0) begin
                check({vecs[v].name, ".first_rd_lat"}, first_rd_cyc - trig_cyc, 1);
                check({vecs[v].name, ".first_valid_lat"}, first_valid_cyc - trig_cyc, 2);
                check({vecs[v].name, ".last_beat_lat"}, last_xfer_cyc - trig_cyc, 1025);
                check({vecs[v].name, ".done_lat"}, done_cyc - trig_cyc, 1026);
            end
        end

        // Long stall right after the trigger: only two reads may be outstanding.
        fill(2);
        clear_mon();
        m_axis.m_ready = 1'b0;
        start_frame();
        repeat (100) @(negedge clk);
        check("stall.reads", n_rd, 2);
        check("stall.addr_err", addr_err, 0);
        check("stall.m_valid", m_axis.m_valid, 1);
        check("stall.m_data", m_axis.m_data, 13'h1FF0);
        @(posedge clk);
        #1 m_axis.m_ready = 1'b1;
        wait_end("stall", 3000);
        verify_frame("stall", 2, 'h1FF0, 8372224);
        check("stall.no_gap", last_xfer_cyc - first_xfer_cyc, FRAME_BEATS - 1);

        // conv_busy rises again after beat 500: abort, then a clean restart.
        fill(0);
        clear_mon();
        start_frame();
        wait_beats("abort", 501, 3000);
        @(posedge clk);
        #1 conv_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort.m_valid", m_axis.m_valid, 0);
        check("abort.err_overrun", err_overrun, 1);
        check("abort.csel", l1_csel, 0);
        rd_snap = n_rd;
        repeat (20) @(negedge clk);
        check("abort.no_reads", n_rd, rd_snap);
        check("abort.err_pulses", n_err, 1);
        check("abort.no_done", n_done, 0);
        clear_mon();
        start_frame();
        wait_end("restart", 3000);
        verify_frame("restart", 0, 8184, 4190208);

        // Asynchronous reset in the middle of a frame.
        clear_mon();
        start_frame();
        wait_beats("rst", 301, 3000);
        #1 reset = 1'b0;
        #1 check_zero("rst_async");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        clear_mon();
        repeat (20) @(negedge clk);
        check("rst.quiet_reads", n_rd, 0);
        check("rst.quiet_valid", first_valid_cyc, -1);
        start_frame();
        wait_end("rst_frame", 3000);
        verify_frame("rst_frame", 0, 8184, 4190208);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
